rr_arbiter_4: RTL and testbench
===============================

# rr_arbiter_4

Four-requester round-robin arbiter that shares one downstream resource, such as a 4-to-2 encoder-indexed datapath, among four clients. It registers a one-hot grant together with its 2-bit encoded index. A grant is held while the winner keeps its request high, and the arbiter forces a release after a programmable hold limit. It sits between the requesting clients and the shared resource; the resource uses `gnt_idx` as its select.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive GRANT cycles per winner; legal range 0..255; 0 disables the timeout.
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: arbitration enable; when low, no new grant is issued, and a grant in progress runs to normal completion.
- `req` input [3:0]: level requests; bit i is held high by client i for as long as it needs the resource.
- `gnt` output [3:0]: registered one-hot grant; all zero when idle.
- `gnt_idx` output [1:0]: registered binary index of the granted bit; holds its last value when `gnt_valid`=0.
- `gnt_valid` output 1: registered; high exactly when `gnt` != 0.
- `preempt` output 1: one-cycle pulse on the edge where a grant is removed by timeout.

## Operation
- **States.**
  - Two states: IDLE and GRANT.
  - Internal registers: `last[1:0]` (index of the most recent winner) and an 8-bit `hold_cnt`.
- **Reset values.** `rst`=1 at an edge forces:
  - state=IDLE, `gnt`=0, `gnt_idx`=0, `gnt_valid`=0, `preempt`=0;
  - `last`=3, so requester 0 has top priority after reset;
  - `hold_cnt`=0.
  - Reset mid-grant drops `gnt` at that edge, with no `preempt` pulse.
- **IDLE.**
  - Transition: if `en`=1 and `req`!=0, go to GRANT.
  - Winner: the first set bit of `req` searching `last`+1, `last`+2, `last`+3, `last` (mod 4, wrapping 3 to 0).
  - On entry: `gnt`=onehot(winner), `gnt_idx`=winner, `gnt_valid`=1, `hold_cnt`=0.
  - Otherwise remain in IDLE with all outputs unchanged.
- **GRANT, normal release.** If `req[gnt_idx]`=0:
  - go to IDLE; clear `gnt` and `gnt_valid`; set `last`=`gnt_idx`; `preempt`=0.
- **GRANT, timeout.** Else if `MAX_HOLD`!=0 and `hold_cnt`==`MAX_HOLD`-1:
  - go to IDLE; clear `gnt`/`gnt_valid`; set `last`=`gnt_idx`; `preempt`=1 for one cycle.
  - The preempted client must drop and re-raise, or keep holding, its request. It is rearbitrated at lowest priority.
- **GRANT, otherwise.** `hold_cnt`++ (saturating at 255); outputs unchanged.
- **Fixed rules.**
  - Requests from non-granted clients never affect an active grant.
  - `en` is ignored in GRANT.
  - `gnt` is always zero or exactly one-hot.
  - `gnt_idx` is always the encoded form of `gnt` while `gnt_valid`=1: bit1 = `gnt[2]`|`gnt[3]`, bit0 = `gnt[1]`|`gnt[3]`.
  - `preempt` is 0 on every edge other than a timeout edge.

## Timing
- **Grant latency.** A request sampled at edge k in IDLE produces `gnt` high from edge k (visible in cycle k+1). That is a minimum latency of 1 cycle from `req` rising.
- **Release latency.** `req[gnt_idx]` sampled low at edge m clears `gnt` at edge m. The resource sees its last granted cycle as cycle m.
- **Dead cycle.** At least one cycle with `gnt`=0 separates any two grants, because IDLE always lasts at least one edge. Back-to-back grants are therefore spaced by exactly 1 idle cycle when requests are pending.
- **Timeout length.** A grant lasts exactly `MAX_HOLD` cycles with `gnt` high. `preempt` is high in the first cycle after `gnt` falls.
- **Simultaneous events.**
  - Release and timeout on the same edge count as a normal release, with `preempt`=0.
  - `rst` takes priority over everything.
  - Requests that change on the same edge as arbitration use the sampled value.
- **Worst-case wait.** A continuously requesting client with `MAX_HOLD`=N waits at most 3*(N+1)+1 cycles.

## Test plan
- **Reset and single request.** Apply `rst` for 2 cycles, then `req`=0001 with `en`=1.
  - Required: `gnt`=0001, `gnt_idx`=00, `gnt_valid`=1 one edge later.
  - Then drop `req` → `gnt`=0000 at the next edge; `preempt` stays 0.
- **Round robin.** Hold `req`=1111 with each winner releasing after 2 cycles.
  - Required: grant order 0,1,2,3,0 with `gnt_idx` 00,01,10,11,00.
  - Exactly 1 idle cycle between grants.
- **Wrap and skip.** With `last`=2, apply `req`=0101.
  - Required: client 0 wins, since search order is 3,0 and client 3 is not requesting; `gnt_idx`=00.
- **Timeout.** With `MAX_HOLD`=4, hold `req`=0011 continuously.
  - Required: client 0 is granted for exactly 4 cycles, then `preempt`=1 for 1 cycle.
  - Client 1 is granted after 1 idle cycle.
- **Enable and reset mid-grant.** First: `en`=0 with `req`=1000.
  - Required: no grant; then raising `en` grants `gnt`=1000 one edge later.
  - Second: assert `rst` during that grant.
  - Required: `gnt`=0, `gnt_idx`=0, `preempt`=0 at that edge; next winner search starts at 0.

Source files
------------

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with registered one-hot grant, encoded index
// and a programmable hold limit that forces release with a one-cycle preempt pulse.
module rr_arbiter_4 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       preempt
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam int unsigned HOLD_W     = 8;
    localparam bit          TIMEOUT_EN = (MAX_HOLD != 0);
    // Only meaningful when the timeout is enabled; wraps harmlessly for MAX_HOLD=0.
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = {HOLD_W{1'b1}};

    logic [0:0]        state_q,     state_d;
    logic [3:0]        gnt_q,       gnt_d;
    logic [1:0]        gnt_idx_q,   gnt_idx_d;
    logic              gnt_valid_q, gnt_valid_d;
    logic              preempt_q,   preempt_d;
    logic [1:0]        last_q,      last_d;
    logic [HOLD_W-1:0] hold_cnt_q,  hold_cnt_d;

    logic [1:0] win_idx;
    logic [1:0] probe_idx;

    // Priority search last+1, last+2, last+3, last; scanned in reverse so the nearest hit sticks.
    always_comb begin
        win_idx   = last_q;
        probe_idx = last_q;
        for (int k = 4; k >= 1; k--) begin
            probe_idx = last_q + 2'(k);
            if (req[probe_idx]) begin
                win_idx = probe_idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        preempt_d   = 1'b0;
        last_d      = last_q;
        hold_cnt_d  = hold_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (en && (req != 4'b0000)) begin
                    state_d     = ST_GRANT;
                    gnt_d       = 4'b0001 << win_idx;
                    gnt_idx_d   = win_idx;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = '0;
                end
            end
            ST_GRANT: begin
                if (!req[gnt_idx_q]) begin
                    state_d     = ST_IDLE;
                    gnt_d       = 4'b0000;
                    gnt_valid_d = 1'b0;
                    last_d      = gnt_idx_q;
                end else if (TIMEOUT_EN && (hold_cnt_q == HOLD_LAST)) begin
                    state_d     = ST_IDLE;
                    gnt_d       = 4'b0000;
                    gnt_valid_d = 1'b0;
                    last_d      = gnt_idx_q;
                    preempt_d   = 1'b1;
                end else if (hold_cnt_q != HOLD_SAT) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d     = ST_IDLE;
                gnt_d       = 4'b0000;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= 4'b0000;
            gnt_idx_q   <= 2'd0;
            gnt_valid_q <= 1'b0;
            preempt_q   <= 1'b0;
            last_q      <= 2'd3;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            preempt_q   <= preempt_d;
            last_q      <= last_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4 (MAX_HOLD=4): reset, round robin, wrap/skip,
// timeout preemption, enable gating and reset during a grant.
module tb_rr_arbiter_4;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt;

    int n_checks;
    int n_pass;

    rr_arbiter_4 #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_grant(input string tag, input logic [3:0] g, input logic [1:0] idx,
                               input logic v, input logic p);
        check({tag, ".gnt"},       8'(gnt),       8'(g));
        check({tag, ".gnt_idx"},   8'(gnt_idx),   8'(idx));
        check({tag, ".gnt_valid"}, 8'(gnt_valid), 8'(v));
        check({tag, ".preempt"},   8'(preempt),   8'(p));
    endtask

    initial begin
        int rr_order [5];
        logic [3:0] oh;

        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        en  = 1'b0;
        req = 4'b0000;

        step();
        step();
        check_grant("reset", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Single request after reset
        rst = 1'b0;
        en  = 1'b1;
        req = 4'b0001;
        step();
        check_grant("single_gnt", 4'b0001, 2'd0, 1'b1, 1'b0);
        req = 4'b0000;
        step();
        check_grant("single_rel", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Round robin from reset priority, each winner holds two cycles
        rst = 1'b1;
        step();
        rst = 1'b0;
        rr_order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) begin
            oh  = 4'(1 << rr_order[i]);
            req = 4'b1111;
            step();
            check_grant($sformatf("rr%0d_c1", i), oh, 2'(rr_order[i]), 1'b1, 1'b0);
            step();
            check($sformatf("rr%0d_c2.gnt", i), 8'(gnt), 8'(oh));
            req = 4'b1111 & ~oh;
            step();
            check_grant($sformatf("rr%0d_idle", i), 4'b0000, 2'(rr_order[i]), 1'b0, 1'b0);
        end

        // Make client 2 the last winner, then wrap past 3 to 0
        req = 4'b0100;
        step();
        check("wrap_setup.gnt", 8'(gnt), 8'h04);
        req = 4'b0000;
        step();
        req = 4'b0101;
        step();
        check_grant("wrap_skip", 4'b0001, 2'd0, 1'b1, 1'b0);
        req = 4'b0000;
        step();
        check("wrap_rel.gnt", 8'(gnt), 8'h00);

        // Timeout: client 0 holds 4 cycles, then preempt, then client 1
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 4'b0011;
        step();
        check_grant("to_c1", 4'b0001, 2'd0, 1'b1, 1'b0);
        for (int c = 2; c <= 4; c++) begin
            step();
            check($sformatf("to_c%0d.gnt", c), 8'(gnt), 8'h01);
            check($sformatf("to_c%0d.preempt", c), 8'(preempt), 8'h00);
        end
        step();
        check_grant("to_preempt", 4'b0000, 2'd0, 1'b0, 1'b1);
        step();
        check_grant("to_next", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b0000;
        step();
        check_grant("to_rel", 4'b0000, 2'd1, 1'b0, 1'b0);

        // Enable gating
        en  = 1'b0;
        req = 4'b1000;
        step();
        check("en_off0.gnt", 8'(gnt), 8'h00);
        step();
        check("en_off1.gnt_valid", 8'(gnt_valid), 8'h00);
        en = 1'b1;
        step();
        check_grant("en_on", 4'b1000, 2'd3, 1'b1, 1'b0);

        // Reset mid-grant, then search restarts at client 0
        rst = 1'b1;
        step();
        check_grant("rst_mid", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
        req = 4'b1111;
        step();
        check_grant("post_rst", 4'b0001, 2'd0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
